// File: rtl/regfile_pkg.sv
// Shared constants and payload types for the integer register file writeback path.
package regfile_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = $clog2(NREG);

   typedef logic [AW-1:0]   reg_idx_t;
   typedef logic [XLEN-1:0] xlen_t;

   // One regfile write-port transaction
   typedef struct packed {
      logic     we;
      reg_idx_t rd;
      xlen_t    data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant starting at the rotating pointer,
// pointer moves past the winner whenever a grant is issued.
module rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_c_o
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] cand_c, win_c;
   logic          found_c;

   // Scan from ptr_q upward with wrap; first requester wins
   always_comb begin
      gnt_c_o = '0;
      cand_c  = '0;
      win_c   = '0;
      found_c = 1'b0;
      ptr_d   = ptr_q;
      for (int unsigned i = 0; i < N; i++) begin
         cand_c = PW'((32'(ptr_q) + i) % N);
         if (!found_c && req_i[cand_c]) begin
            found_c = 1'b1;
            win_c   = cand_c;
         end
      end
      if (found_c) begin
         gnt_c_o[win_c] = 1'b1;
         ptr_d = (32'(win_c) == N - 1) ? '0 : win_c + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler + scoreboard for the 32x32 integer regfile.
// Optional operand bypass from the write-port register: REGFILE_WB_BYPASS_EN.
module regfile_wb_sched
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_SRC = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*AW-1:0]     src_rd,
   input  logic [NUM_SRC*XLEN-1:0]   src_data,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic                      iss_valid,
   input  reg_idx_t                  iss_rs1,
   input  reg_idx_t                  iss_rs2,
   input  reg_idx_t                  iss_rd,
   input  logic                      iss_rd_we,
   output logic                      iss_ready,
   output logic                      rf_we,
   output reg_idx_t                  rf_rd,
   output xlen_t                     rf_wdata,
`ifdef REGFILE_WB_BYPASS_EN
   output logic                      byp_rs1_hit,
   output logic                      byp_rs2_hit,
   output xlen_t                     byp_data,
`endif
   output logic [NREG-1:0]           busy
);

   logic [NUM_SRC-1:0] req_c, gnt_c;
   logic               hs_c;
   reg_idx_t           sel_rd_c;
   xlen_t              sel_data_c;
   wb_req_t            wb_d, wb_q;
   logic [NREG-1:0]    busy_q, busy_d, set_c, clr_c, haz_c;

   // Grants are withheld while in reset so nothing handshakes then
   assign req_c = rst ? '0 : src_valid;

   rr_arbiter #(.N(NUM_SRC)) u_arb (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req_c),
      .gnt_c_o (gnt_c)
   );

   assign src_ready = gnt_c;

   // Steer the granted slice onto the write port
   always_comb begin
      hs_c       = |gnt_c;
      sel_rd_c   = '0;
      sel_data_c = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (gnt_c[i]) begin
            sel_rd_c   = src_rd[i*AW +: AW];
            sel_data_c = src_data[i*XLEN +: XLEN];
         end
      end
      wb_d.we   = hs_c && (sel_rd_c != '0);
      wb_d.rd   = hs_c ? sel_rd_c   : wb_q.rd;
      wb_d.data = hs_c ? sel_data_c : wb_q.data;
   end

   // Scoreboard update; a same-cycle set overrides the clear
   always_comb begin
      set_c = '0;
      clr_c = '0;
      if (iss_valid && iss_ready && iss_rd_we && (iss_rd != '0)) begin
         set_c[iss_rd] = 1'b1;
      end
      if (wb_d.we) begin
         clr_c[wb_d.rd] = 1'b1;
      end
      busy_d    = (busy_q & ~clr_c) | set_c;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q   <= '0;
         busy_q <= '0;
      end else begin
         wb_q   <= wb_d;
         busy_q <= busy_d;
      end
   end

`ifdef REGFILE_WB_BYPASS_EN
   // In-flight write is forwarded, so the register is free one cycle earlier
   assign haz_c       = busy_q;
   assign byp_rs1_hit = wb_q.we && (wb_q.rd == iss_rs1);
   assign byp_rs2_hit = wb_q.we && (wb_q.rd == iss_rs2);
   assign byp_data    = wb_q.data;
`else
   logic [NREG-1:0] retire_q;

   // Register stays hazardous while its regfile write is still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_q <= '0;
      end else begin
         retire_q <= clr_c;
      end
   end

   assign haz_c = busy_q | retire_q;
`endif

   assign busy      = haz_c;
   assign iss_ready = !rst && !(haz_c[iss_rs1] || haz_c[iss_rs2] ||
                                (iss_rd_we && haz_c[iss_rd]));

   assign rf_we    = wb_q.we;
   assign rf_rd    = wb_q.rd;
   assign rf_wdata = wb_q.data;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed table, corner sequences,
// then random traffic against a cycle-count based hazard model.
module tb_regfile_wb_sched;
   import regfile_pkg::*;

   localparam int unsigned NS = 3;
`ifdef REGFILE_WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic                 clk;
   logic                 rst;
   logic [NS-1:0]        src_valid;
   logic [NS*AW-1:0]     src_rd;
   logic [NS*XLEN-1:0]   src_data;
   logic [NS-1:0]        src_ready;
   logic                 iss_valid;
   logic [AW-1:0]        iss_rs1, iss_rs2, iss_rd;
   logic                 iss_rd_we;
   logic                 iss_ready;
   logic                 rf_we;
   logic [AW-1:0]        rf_rd;
   logic [XLEN-1:0]      rf_wdata;
   logic [NREG-1:0]      busy;
`ifdef REGFILE_WB_BYPASS_EN
   logic                 byp_rs1_hit, byp_rs2_hit;
   logic [XLEN-1:0]      byp_data;
`endif

   regfile_wb_sched #(.NUM_SRC(NS)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid),
      .src_rd    (src_rd),
      .src_data  (src_data),
      .src_ready (src_ready),
      .iss_valid (iss_valid),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .iss_rd_we (iss_rd_we),
      .iss_ready (iss_ready),
      .rf_we     (rf_we),
      .rf_rd     (rf_rd),
      .rf_wdata  (rf_wdata),
`ifdef REGFILE_WB_BYPASS_EN
      .byp_rs1_hit (byp_rs1_hit),
      .byp_rs2_hit (byp_rs2_hit),
      .byp_data    (byp_data),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [AW-1:0] rd,
                          input logic [XLEN-1:0] d);
      src_valid[i]            = v;
      src_rd[i*AW +: AW]      = rd;
      src_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic set_iss(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic we);
      iss_valid = v;
      iss_rs1   = rs1;
      iss_rs2   = rs2;
      iss_rd    = rd;
      iss_rd_we = we;
   endtask

   task automatic idle();
      for (int i = 0; i < int'(NS); i++) set_src(i, 1'b0, '0, '0);
      set_iss(1'b0, '0, '0, '0, 1'b0);
   endtask

   function automatic logic [XLEN-1:0] sdat(input int i, input int rd);
      return 32'hC0DE_0000 + 32'(i * 256) + 32'(rd);
   endfunction

   // Directed vector: inputs followed by expected outputs
   typedef struct {
      logic            rst;
      logic [NS-1:0]   vld;
      logic [AW-1:0]   rd0, rd1, rd2;
      logic [XLEN-1:0] d0;
      logic            iv;
      logic [AW-1:0]   ird;
      logic            iwe;
      logic [NS-1:0]   e_rdy;
      logic            e_we;
      logic [AW-1:0]   e_rd;
      logic            e_irdy;
      logic            cb;
   } vec_t;

   function automatic vec_t mk(input int r, input int v, input int a, input int b, input int c,
                               input logic [31:0] d0, input int iv, input int ird, input int iwe,
                               input int erdy, input int ewe, input int erd, input int eirdy,
                               input int cb);
      vec_t t;
      t.rst = 1'(r);  t.vld = NS'(v);
      t.rd0 = AW'(a); t.rd1 = AW'(b); t.rd2 = AW'(c);
      t.d0  = d0;     t.iv = 1'(iv); t.ird = AW'(ird); t.iwe = 1'(iwe);
      t.e_rdy = NS'(erdy); t.e_we = 1'(ewe); t.e_rd = AW'(erd);
      t.e_irdy = 1'(eirdy); t.cb = 1'(cb);
      return t;
   endfunction

   // Behavioural model state for the random phase
   bit              pending [NREG];
   int              avail_at [NREG];
   int              cyc;
   int              m_ptr;
   bit              m_we;
   logic [AW-1:0]   m_rd;
   logic [XLEN-1:0] m_data;

   function automatic bit haz(input int r);
      return (r != 0) && (pending[r] || (cyc < avail_at[r]));
   endfunction

   task automatic model_clear();
      for (int r = 0; r < int'(NREG); r++) begin
         pending[r]  = 1'b0;
         avail_at[r] = 0;
      end
      m_ptr = 0;
      m_we  = 1'b0;
      m_rd  = '0;
      m_data = '0;
   endtask

   vec_t tbl [14];

   initial begin
      tbl[0]  = mk(1, 7, 1, 2, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 7, 1, 2, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 7, 1, 2, 3, 0, 0, 0, 0,  1, 0, 0, 1, 1);
      tbl[3]  = mk(0, 7, 1, 2, 3, 0, 0, 0, 0,  2, 1, 1, 1, 0);
      tbl[4]  = mk(0, 7, 1, 2, 3, 0, 0, 0, 0,  4, 1, 2, 1, 0);
      tbl[5]  = mk(0, 7, 1, 2, 3, 0, 0, 0, 0,  1, 1, 3, 1, 0);
      tbl[6]  = mk(0, 0, 1, 2, 3, 0, 0, 0, 0,  0, 1, 1, 1, 0);
      tbl[7]  = mk(0, 0, 1, 2, 3, 0, 0, 0, 0,  0, 0, 0, 1, 0);
      tbl[8]  = mk(0, 6, 1, 2, 3, 0, 0, 0, 0,  2, 0, 0, 1, 0);
      tbl[9]  = mk(0, 5, 1, 2, 3, 0, 0, 0, 0,  4, 1, 2, 1, 0);
      tbl[10] = mk(0, 3, 1, 2, 3, 0, 0, 0, 0,  1, 1, 3, 1, 0);
      tbl[11] = mk(0, 1, 0, 2, 3, 32'hDEAD_BEEF, 0, 0, 0, 1, 1, 1, 1, 0);
      tbl[12] = mk(0, 0, 0, 2, 3, 0, 1, 0, 1,  0, 0, 0, 1, 0);
      tbl[13] = mk(0, 0, 0, 2, 3, 0, 0, 0, 0,  0, 0, 0, 1, 1);

      src_valid = '0; src_rd = '0; src_data = '0;
      set_iss(1'b0, '0, '0, '0, 1'b0);
      rst = 1'b1;

      // Reset, round-robin, x0 writes and x0 issue
      for (int r = 0; r < 14; r++) begin
         rst = tbl[r].rst;
         set_src(0, tbl[r].vld[0], tbl[r].rd0,
                 (tbl[r].d0 != 0) ? tbl[r].d0 : sdat(0, int'(tbl[r].rd0)));
         set_src(1, tbl[r].vld[1], tbl[r].rd1, sdat(1, int'(tbl[r].rd1)));
         set_src(2, tbl[r].vld[2], tbl[r].rd2, sdat(2, int'(tbl[r].rd2)));
         set_iss(tbl[r].iv, '0, '0, tbl[r].ird, tbl[r].iwe);
         @(negedge clk);
         if (!tbl[r].rst) begin
            chk($sformatf("tbl%0d_src_ready", r), 64'(src_ready), 64'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d_rf_we", r), 64'(rf_we), 64'(tbl[r].e_we));
            if (tbl[r].e_we) chk($sformatf("tbl%0d_rf_rd", r), 64'(rf_rd), 64'(tbl[r].e_rd));
            chk($sformatf("tbl%0d_iss_ready", r), 64'(iss_ready), 64'(tbl[r].e_irdy));
            if (tbl[r].cb) chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(0));
         end
         tick();
      end

      // RAW on x5 written by source 2
      idle();
      set_iss(1'b1, '0, '0, 5'd5, 1'b1);
      @(negedge clk); chk("raw_issue_ready", 64'(iss_ready), 64'(1));
      tick();
      set_iss(1'b1, 5'd5, '0, '0, 1'b0);
      @(negedge clk);
      chk("raw_stall", 64'(iss_ready), 64'(0));
      chk("raw_busy5", 64'(busy[5]), 64'(1));
      tick();
      set_src(2, 1'b1, 5'd5, 32'h1234_5678);
      @(negedge clk);
      chk("raw_grant", 64'(src_ready), 64'(4));
      chk("raw_stall_n", 64'(iss_ready), 64'(0));
      tick();
      set_src(2, 1'b0, '0, '0);
      @(negedge clk);
      chk("raw_rf_we", 64'(rf_we), 64'(1));
      chk("raw_rf_rd", 64'(rf_rd), 64'(5));
      chk("raw_rf_wdata", 64'(rf_wdata), 64'(32'h1234_5678));
`ifdef REGFILE_WB_BYPASS_EN
      chk("raw_ready_n1", 64'(iss_ready), 64'(1));
      chk("raw_byp_hit1", 64'(byp_rs1_hit), 64'(1));
      chk("raw_byp_hit2", 64'(byp_rs2_hit), 64'(0));
      chk("raw_byp_data", 64'(byp_data), 64'(32'h1234_5678));
`else
      chk("raw_ready_n1", 64'(iss_ready), 64'(0));
`endif
      tick();
      @(negedge clk); chk("raw_ready_n2", 64'(iss_ready), 64'(1));
      tick();

      // Same-cycle clear and set of x7: set wins
      idle();
      set_src(0, 1'b1, 5'd7, 32'h0000_0077);
      set_iss(1'b1, '0, '0, 5'd7, 1'b1);
      @(negedge clk);
      chk("sw_iss_ready", 64'(iss_ready), 64'(1));
      chk("sw_grant", 64'(src_ready), 64'(1));
      tick();
      idle();
      tick();
      @(negedge clk);
      chk("sw_busy7", 64'(busy[7]), 64'(1));
      set_iss(1'b1, 5'd7, '0, '0, 1'b0);
      #1 chk("sw_stall7", 64'(iss_ready), 64'(0));
      tick();

      // Reset while x3 busy and source 1 granted
      idle();
      set_iss(1'b1, '0, '0, 5'd3, 1'b1);
      tick();
      idle();
      set_src(1, 1'b1, 5'd3, 32'h3333_3333);
      @(negedge clk);
      chk("rst_busy3", 64'(busy[3]), 64'(1));
      chk("rst_grant1", 64'(src_ready), 64'(2));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      @(negedge clk);
      chk("rst_rf_we", 64'(rf_we), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_iss_ready", 64'(iss_ready), 64'(1));
      tick();

      // Random traffic against the reference model
      model_clear();
      cyc = 0;
      for (int n = 0; n < 3000; n++) begin
         int               g;
         logic [NS-1:0]    erdy;
         logic [NREG-1:0]  ebusy;
         logic             eirdy;
         logic [AW-1:0]    wrd;
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < int'(NS); i++)
            set_src(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
         set_iss(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         @(negedge clk);
         if (rst) begin
            model_clear();
         end else begin
            g = -1;
            for (int k = 0; k < int'(NS); k++) begin
               int idx;
               idx = (m_ptr + k) % int'(NS);
               if (g < 0 && src_valid[idx]) g = idx;
            end
            erdy = (g < 0) ? '0 : NS'(1 << g);
            eirdy = !(haz(int'(iss_rs1)) || haz(int'(iss_rs2)) ||
                      (iss_rd_we && haz(int'(iss_rd))));
            for (int r = 0; r < int'(NREG); r++) ebusy[r] = haz(r);
            chk("rnd_src_ready", 64'(src_ready), 64'(erdy));
            chk("rnd_iss_ready", 64'(iss_ready), 64'(eirdy));
            chk("rnd_rf_we", 64'(rf_we), 64'(m_we));
            if (m_we) begin
               chk("rnd_rf_rd", 64'(rf_rd), 64'(m_rd));
               chk("rnd_rf_wdata", 64'(rf_wdata), 64'(m_data));
            end
            chk("rnd_busy", 64'(busy), 64'(ebusy));
`ifdef REGFILE_WB_BYPASS_EN
            chk("rnd_byp1", 64'(byp_rs1_hit), 64'(m_we && (m_rd == iss_rs1)));
            chk("rnd_byp2", 64'(byp_rs2_hit), 64'(m_we && (m_rd == iss_rs2)));
            if (m_we) chk("rnd_byp_data", 64'(byp_data), 64'(m_data));
`endif
            m_we = 1'b0;
            if (g >= 0) begin
               wrd    = src_rd[g*AW +: AW];
               m_ptr  = (g + 1) % int'(NS);
               m_rd   = wrd;
               m_data = src_data[g*XLEN +: XLEN];
               if (wrd != '0) begin
                  m_we = 1'b1;
                  pending[wrd]  = 1'b0;
                  avail_at[wrd] = cyc + LAT;
               end
            end
            if (iss_valid && eirdy && iss_rd_we && (iss_rd != '0)) pending[iss_rd] = 1'b1;
         end
         cyc++;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
